dmem_ctrl: RTL and testbench

Two-port arbiter and access sequencer in front of the single-port data memory (combinational read, synchronous word write). It shares the memory between the core load/store unit (port 0) and a debug/DMA requester (port 1) using round-robin arbitration. It converts byte and halfword stores into read-modify-write word sequences, and checks alignment and address range. It sits between the LSU/debug fabric and the data memory instance.

---
 rtl/dmem_ctrl_if.sv | 38 +++
 rtl/dmem_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: bundles both requester ports (p0 = LSU, p1 = debug/DMA)
// and the single-port data memory bus of dmem_ctrl.
interface dmem_ctrl_if;
  logic        p0_req_valid, p0_req_ready, p0_req_we;
  logic [1:0]  p0_req_size;
  logic [31:0] p0_req_addr, p0_req_wdata;
  logic        p0_rsp_valid, p0_rsp_err;
  logic [31:0] p0_rsp_rdata;

  logic        p1_req_valid, p1_req_ready, p1_req_we;
  logic [1:0]  p1_req_size;
  logic [31:0] p1_req_addr, p1_req_wdata;
  logic        p1_rsp_valid, p1_rsp_err;
  logic [31:0] p1_rsp_rdata;

  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  // Requester fabric plus memory model side.
  modport master (
    output p0_req_valid, p0_req_we, p0_req_size, p0_req_addr, p0_req_wdata,
    input  p0_req_ready, p0_rsp_valid, p0_rsp_err, p0_rsp_rdata,
    output p1_req_valid, p1_req_we, p1_req_size, p1_req_addr, p1_req_wdata,
    input  p1_req_ready, p1_rsp_valid, p1_rsp_err, p1_rsp_rdata,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

  // Controller side.
  modport slave (
    input  p0_req_valid, p0_req_we, p0_req_size, p0_req_addr, p0_req_wdata,
    output p0_req_ready, p0_rsp_valid, p0_rsp_err, p0_rsp_rdata,
    input  p1_req_valid, p1_req_we, p1_req_size, p1_req_addr, p1_req_wdata,
    output p1_req_ready, p1_rsp_valid, p1_rsp_err, p1_rsp_rdata,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: two-port round-robin arbiter and access sequencer in front of a
// single-port data memory (combinational read, synchronous word write).
// Optional feature macro: DMEM_CTRL_RMW_EN -- when defined, byte/halfword
// stores run as read-modify-write (ACCESS -> WRITE); when undefined the WRITE
// state does not exist and sub-word stores complete with err=1, no write.
module dmem_ctrl #(
  parameter int MEM_BYTES = 128
) (
  input logic        clk,
  input logic        reset,
  dmem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
`ifdef DMEM_CTRL_RMW_EN
    WRITE  = 2'd2,
`endif
    RESP   = 2'd3
  } state_t;

  typedef struct packed {
    logic        owner;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t           state;
  req_t             cur;
  req_t [1:0]       in_req;
  logic             last_grant;
  logic [1:0]       valid, grant, ready;
  logic [1:0]       rsp_valid_q, rsp_err_q;
  logic [1:0][31:0] rsp_rdata_q;

  assign valid     = {bus.p1_req_valid, bus.p0_req_valid};
  assign in_req[0] = {1'b0, bus.p0_req_we, bus.p0_req_size, bus.p0_req_addr, bus.p0_req_wdata};
  assign in_req[1] = {1'b1, bus.p1_req_we, bus.p1_req_size, bus.p1_req_addr, bus.p1_req_wdata};

  assign bus.p0_req_ready = ready[0];
  assign bus.p1_req_ready = ready[1];
  assign bus.p0_rsp_valid = rsp_valid_q[0];
  assign bus.p1_rsp_valid = rsp_valid_q[1];
  assign bus.p0_rsp_rdata = rsp_rdata_q[0];
  assign bus.p1_rsp_rdata = rsp_rdata_q[1];
  assign bus.p0_rsp_err   = rsp_err_q[0];
  assign bus.p1_rsp_err   = rsp_err_q[1];

  // Round-robin: a lone requester wins; on contention the port not granted last wins.
  always_comb begin
    grant[0] = valid[0] & (~valid[1] | last_grant);
    grant[1] = valid[1] & (~valid[0] | ~last_grant);
    ready    = (state == IDLE && !reset) ? grant : 2'b00;
  end

  logic [4:0]  sh;
  logic [31:0] shifted, load_data;
  logic        misalign, acc_err;

  // Decode the captured request: error check and right-aligned load data.
  always_comb begin
    sh       = {cur.addr[1:0], 3'b000};
    shifted  = bus.mem_rdata >> sh;
    case (cur.size)
      2'b00:   load_data = {24'd0, shifted[7:0]};
      2'b01:   load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
    misalign = (cur.size == 2'b01 && cur.addr[0]) ||
               (cur.size == 2'b10 && cur.addr[1:0] != 2'b00);
    acc_err  = (cur.size == 2'b11) || misalign || (cur.addr >= 32'(MEM_BYTES));
`ifndef DMEM_CTRL_RMW_EN
    // No merge path: any sub-word store is rejected.
    if (cur.we && cur.size != 2'b10) acc_err = 1'b1;
`endif
  end

`ifdef DMEM_CTRL_RMW_EN
  logic [31:0] lane_mask, merged, merged_q;

  // Splice the store bytes into the word currently held in memory.
  always_comb begin
    lane_mask = ((cur.size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    merged    = (bus.mem_rdata & ~lane_mask) | ((cur.wdata << sh) & lane_mask);
  end
`endif

  logic        done, done_err;
  logic [31:0] done_data;

  // Completion: ACCESS finishes unless a merge write follows; WRITE always finishes.
  always_comb begin
    done      = 1'b0;
    done_err  = 1'b0;
    done_data = 32'd0;
    case (state)
      ACCESS: begin
        done_err = acc_err;
        if (!acc_err && !cur.we) done_data = load_data;
`ifdef DMEM_CTRL_RMW_EN
        done = acc_err || !cur.we || cur.size == 2'b10;
`else
        done = 1'b1;
`endif
      end
`ifdef DMEM_CTRL_RMW_EN
      WRITE: done = 1'b1;
`endif
      default: ;
    endcase
  end

  // Memory bus; held low during reset so an interrupted sequence never writes.
  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 32'd0;
    bus.mem_wdata = 32'd0;
    if (!reset) begin
      case (state)
        ACCESS: begin
          bus.mem_addr = {cur.addr[31:2], 2'b00};
          if (cur.we && cur.size == 2'b10 && !acc_err) begin
            bus.mem_we    = 1'b1;
            bus.mem_wdata = cur.wdata;
          end
        end
`ifdef DMEM_CTRL_RMW_EN
        WRITE: begin
          bus.mem_we    = 1'b1;
          bus.mem_addr  = {cur.addr[31:2], 2'b00};
          bus.mem_wdata = merged_q;
        end
`endif
        default: ;
      endcase
    end
  end

  // Sequencer FSM with registered response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      cur         <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      rsp_rdata_q <= '0;
`ifdef DMEM_CTRL_RMW_EN
      merged_q    <= '0;
`endif
    end else begin
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      rsp_rdata_q <= '0;
      case (state)
        IDLE: begin
          if (|ready) begin
            cur        <= ready[1] ? in_req[1] : in_req[0];
            last_grant <= ready[1];
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (done) state <= RESP;
`ifdef DMEM_CTRL_RMW_EN
          else begin
            merged_q <= merged;
            state    <= WRITE;
          end
`endif
        end
`ifdef DMEM_CTRL_RMW_EN
        WRITE: state <= RESP;
`endif
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (done) begin
        rsp_valid_q[cur.owner] <= 1'b1;
        rsp_err_q[cur.owner]   <= done_err;
        rsp_rdata_q[cur.owner] <= done_data;
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed stimulus against dmem_ctrl with a transaction-level
// byte-memory model that predicts every cycle's ready, response and write.
module tb_dmem_ctrl;
  localparam int MB = 128;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  dmem_ctrl_if bus();
  dmem_ctrl #(.MEM_BYTES(MB)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Physical memory driven by the DUT.
  logic [31:0] mem [32] = '{default: 32'd0};
  assign bus.mem_rdata = mem[bus.mem_addr[6:2]];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[6:2]] <= bus.mem_wdata;

  logic [1:0]       v_w, rdy_w, rv_w, re_w;
  logic [1:0]       we_w;
  logic [1:0][1:0]  sz_w;
  logic [1:0][31:0] a_w, wd_w, rd_w;
  assign v_w   = {bus.p1_req_valid, bus.p0_req_valid};
  assign rdy_w = {bus.p1_req_ready, bus.p0_req_ready};
  assign rv_w  = {bus.p1_rsp_valid, bus.p0_rsp_valid};
  assign re_w  = {bus.p1_rsp_err, bus.p0_rsp_err};
  assign we_w  = {bus.p1_req_we, bus.p0_req_we};
  assign sz_w  = {bus.p1_req_size, bus.p0_req_size};
  assign a_w   = {bus.p1_req_addr, bus.p0_req_addr};
  assign wd_w  = {bus.p1_req_wdata, bus.p0_req_wdata};
  assign rd_w  = {bus.p1_rsp_rdata, bus.p0_rsp_rdata};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  byte unsigned refm [MB] = '{default: 8'd0};
  bit          pend = 1'b0;
  bit          lastg = 1'b1;
  int          t_own, t_rsp, t_we, t_wa;
  bit          t_err;
  logic [31:0] t_rd, t_wword;
  int          glog[$];

  function automatic logic [31:0] ref_word(input int wa);
    return {refm[wa+3], refm[wa+2], refm[wa+1], refm[wa]};
  endfunction

  function automatic bit model_err(input logic we, input logic [1:0] sz, input logic [31:0] a);
    int nb;
    if (sz == 2'b11) return 1'b1;
    nb = 1 << sz;
    if (a % nb != 0) return 1'b1;
    if (a >= MB) return 1'b1;
`ifndef DMEM_CTRL_RMW_EN
    if (we && nb < 4) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // Compare process: every falling edge, check the DUT against the model.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      if (cyc > 0) begin
        chk("rst_ready", 32'(rdy_w), 0);
        chk("rst_rsp_valid", 32'(rv_w), 0);
        chk("rst_rsp_err", 32'(re_w), 0);
        chk("rst_rdata0", bus.p0_rsp_rdata, 0);
        chk("rst_rdata1", bus.p1_rsp_rdata, 0);
        chk("rst_mem_we", 32'(bus.mem_we), 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
      end
      pend  = 1'b0;
      lastg = 1'b1;
    end else begin
      logic [1:0] er;
      bit         ewe;
      er = 2'b00;
      if (!pend) begin
        er[0] = v_w[0] && (!v_w[1] || lastg);
        er[1] = v_w[1] && (!v_w[0] || !lastg);
      end
      chk("ready", 32'(rdy_w), 32'(er));
      for (int p = 0; p < 2; p++) begin
        bit erv;
        erv = pend && cyc == t_rsp && t_own == p;
        chk($sformatf("rsp_valid%0d", p), 32'(rv_w[p]), 32'(erv));
        if (erv) begin
          chk($sformatf("rsp_rdata%0d", p), rd_w[p], t_rd);
          chk($sformatf("rsp_err%0d", p), 32'(re_w[p]), 32'(t_err));
        end
      end
      ewe = pend && cyc == t_we;
      chk("mem_we", 32'(bus.mem_we), 32'(ewe));
      if (ewe) begin
        chk("mem_addr", bus.mem_addr, 32'(t_wa));
        chk("mem_wdata", bus.mem_wdata, t_wword);
        for (int i = 0; i < 4; i++) refm[t_wa+i] = t_wword[8*i +: 8];
      end
      if (pend && cyc == t_rsp) begin
        pend = 1'b0;
        if (t_wa >= 0) chk("mem_word", mem[t_wa >> 2], ref_word(t_wa));
      end
      for (int p = 0; p < 2; p++) begin
        if (er[p] && v_w[p]) begin
          int nb, ai;
          nb    = 1 << sz_w[p];
          ai    = int'(a_w[p]);
          t_own = p;
          t_err = model_err(we_w[p], sz_w[p], a_w[p]);
          t_rd  = 32'd0;
          t_we  = -1;
          t_wa  = (a_w[p] < MB) ? (ai & ~3) : -1;
          if (!t_err && !we_w[p])
            for (int i = 0; i < nb; i++) t_rd |= 32'(refm[ai+i]) << (8*i);
          if (!t_err && we_w[p]) begin
            t_wword = ref_word(t_wa);
            for (int i = 0; i < nb; i++) t_wword[8*((ai % 4) + i) +: 8] = wd_w[p][8*i +: 8];
            t_we = cyc + ((nb == 4) ? 1 : 2);
          end
          t_rsp = cyc + ((!t_err && we_w[p] && nb < 4) ? 3 : 2);
          pend  = 1'b1;
          lastg = p[0];
          glog.push_back(p);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input int p, input logic v, input logic we, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
    if (p == 0) begin
      bus.p0_req_valid = v; bus.p0_req_we = we; bus.p0_req_size = sz;
      bus.p0_req_addr = a; bus.p0_req_wdata = wd;
    end else begin
      bus.p1_req_valid = v; bus.p1_req_we = we; bus.p1_req_size = sz;
      bus.p1_req_addr = a; bus.p1_req_wdata = wd;
    end
  endtask

  task automatic set_valid(input int p, input logic v);
    if (p == 0) bus.p0_req_valid = v; else bus.p1_req_valid = v;
  endtask

  task automatic issue(input int p, input logic we, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, output int hs);
    drive(p, 1'b1, we, sz, a, wd);
    hs = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (rdy_w[p]) begin hs = cyc; break; end
    end
    if (hs < 0) chk("handshake_timeout", 1, 0);
    @(posedge clk); #1;
    set_valid(p, 1'b0);
  endtask

  task automatic wait_rsp(input int p, input int hs, input int lat, input logic [31:0] erd,
                          input logic eerr, input string nm);
    int got;
    logic [31:0] lv;
    got = -1;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (rv_w[p]) begin got = cyc; break; end
    end
    lv = (got < 0) ? 32'hFFFF_FFFF : 32'(got - hs);
    chk({nm, "_lat"}, lv, 32'(lat));
    if (got >= 0) begin
      chk({nm, "_rdata"}, rd_w[p], erd);
      chk({nm, "_err"}, 32'(re_w[p]), 32'(eerr));
    end
    @(posedge clk); #1;
  endtask

  task automatic xact(input int p, input logic we, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, input int lat, input logic [31:0] erd,
                      input logic eerr, input string nm);
    int hs;
    issue(p, we, sz, a, wd, hs);
    if (hs >= 0) wait_rsp(p, hs, lat, erd, eerr, nm);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int hs, c0;
    drive(0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", 32'(rdy_w), 0);
    @(posedge clk); #1;

    // Word store then load.
    xact(0, 1'b1, 2'b10, 32'h10, 32'hDEAD_BEEF, 2, 32'd0, 1'b0, "w10_st");
    xact(0, 1'b0, 2'b10, 32'h10, 32'd0, 2, 32'hDEAD_BEEF, 1'b0, "w10_ld");

    // Contention right after reset: grants alternate starting with port 0.
    do_reset(2);
    glog.delete();
    drive(0, 1'b1, 1'b0, 2'b10, 32'h10, 32'd0);
    drive(1, 1'b1, 1'b0, 2'b10, 32'h20, 32'd0);
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (glog.size() >= 4) break;
    end
    @(posedge clk); #1;
    set_valid(0, 1'b0);
    set_valid(1, 1'b0);
    repeat (4) @(posedge clk); #1;
    chk("grant_count", 32'(glog.size() >= 4), 1);
    if (glog.size() >= 4) begin
      chk("grant0", 32'(glog[0]), 0);
      chk("grant1", 32'(glog[1]), 1);
      chk("grant2", 32'(glog[2]), 0);
      chk("grant3", 32'(glog[3]), 1);
    end

    // Sub-word store into an existing word, then halfword readback.
    xact(1, 1'b1, 2'b10, 32'h20, 32'h1122_3344, 2, 32'd0, 1'b0, "w20_st");
`ifdef DMEM_CTRL_RMW_EN
    xact(0, 1'b1, 2'b00, 32'h22, 32'h0000_00AA, 3, 32'd0, 1'b0, "b22_st");
    chk("mem20_rmw", mem[8], 32'h11AA_3344);
    xact(0, 1'b0, 2'b01, 32'h22, 32'd0, 2, 32'h0000_11AA, 1'b0, "h22_ld");
`else
    xact(0, 1'b1, 2'b00, 32'h22, 32'h0000_00AA, 2, 32'd0, 1'b1, "b22_st");
    chk("mem20_keep", mem[8], 32'h1122_3344);
    xact(0, 1'b0, 2'b01, 32'h22, 32'd0, 2, 32'h0000_1122, 1'b0, "h22_ld");
`endif

    // Byte/half loads at lane 3 and lane 2, plus a byte store to lane 0.
    xact(1, 1'b1, 2'b10, 32'h00, 32'h80FF_0000, 2, 32'd0, 1'b0, "w00_st");
`ifdef DMEM_CTRL_RMW_EN
    xact(1, 1'b1, 2'b00, 32'h00, 32'h0000_0011, 3, 32'd0, 1'b0, "b00_st");
    chk("mem00_rmw", mem[0], 32'h80FF_0011);
`else
    xact(1, 1'b1, 2'b00, 32'h00, 32'h0000_0011, 2, 32'd0, 1'b1, "b00_st");
    chk("mem00_keep", mem[0], 32'h80FF_0000);
`endif
    xact(0, 1'b0, 2'b00, 32'h03, 32'd0, 2, 32'h0000_0080, 1'b0, "b03_ld");
    xact(1, 1'b0, 2'b01, 32'h02, 32'd0, 2, 32'h0000_80FF, 1'b0, "h02_ld");

    // Error cases: misaligned, out of range, illegal size.
    xact(0, 1'b1, 2'b01, 32'h21, 32'h0000_BEEF, 2, 32'd0, 1'b1, "h21_st");
    xact(1, 1'b0, 2'b10, 32'h06, 32'd0, 2, 32'd0, 1'b1, "w06_ld");
    xact(0, 1'b0, 2'b10, 32'h80, 32'd0, 2, 32'd0, 1'b1, "w80_ld");
    xact(1, 1'b1, 2'b00, 32'h80, 32'h0000_0012, 2, 32'd0, 1'b1, "b80_st");
    xact(0, 1'b0, 2'b11, 32'h00, 32'd0, 2, 32'd0, 1'b1, "sz3_ld");
    chk("mem20_after_err", mem[8], 32'h11AA_3344 ^
`ifdef DMEM_CTRL_RMW_EN
        32'h0
`else
        32'h0088_0000
`endif
        );

    // Reset while a word store is in ACCESS: write must not happen.
    issue(0, 1'b1, 2'b10, 32'h34, 32'h1234_5678, hs);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("rst_access_nowrite", mem[13], 32'd0);
    xact(1, 1'b0, 2'b10, 32'h34, 32'd0, 2, 32'd0, 1'b0, "w34_ld");

`ifdef DMEM_CTRL_RMW_EN
    // Reset while a byte store is in WRITE: no write, no response, ready next cycle.
    issue(0, 1'b1, 2'b00, 32'h31, 32'h0000_0055, hs);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    c0 = cyc;
    issue(1, 1'b0, 2'b10, 32'h30, 32'd0, hs);
    chk("ready_after_reset", 32'(hs), 32'(c0));
    wait_rsp(1, hs, 2, 32'd0, 1'b0, "w30_ld");
    chk("rst_write_nowrite", mem[12], 32'd0);
`endif

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
